// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared funct codes and mul/div FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam logic [5:0] c_FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] c_FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] c_FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] c_FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] c_FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] c_FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] c_FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] c_FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

   function automatic logic is_muldiv(input logic [5:0] func);
      return (func == c_FUNCT_MULT) || (func == c_FUNCT_MULTU) ||
             (func == c_FUNCT_DIV)  || (func == c_FUNCT_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [5:0] func);
      return (func == c_FUNCT_DIV) || (func == c_FUNCT_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [5:0] func);
      return (func == c_FUNCT_MULT) || (func == c_FUNCT_DIV);
   endfunction

   function automatic logic is_hilo_move(input logic [5:0] func);
      return (func == c_FUNCT_MFHI) || (func == c_FUNCT_MFLO) ||
             (func == c_FUNCT_MTHI) || (func == c_FUNCT_MTLO);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit_if.sv
// ============================================================================
// mul_div_unit_if : issue/result bundle between the EX stage and the mul/div unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start_in;
   logic [5:0]       Func_in;
   logic [WIDTH-1:0] A_in;
   logic [WIDTH-1:0] B_in;
   logic [WIDTH-1:0] O_out;
   logic             Busy_out;
   logic             Done_out;
   logic             Stall_out;

   modport master (
      output Start_in, Func_in, A_in, B_in,
      input  O_out, Busy_out, Done_out, Stall_out
   );

   modport slave (
      input  Start_in, Func_in, A_in, B_in,
      output O_out, Busy_out, Done_out, Stall_out
   );
endinterface

`default_nettype wire

// File: rtl/mdu_datapath.sv
// ============================================================================
// mdu_datapath : shift-add multiplier / restoring divider with sign fix-up
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_datapath #(
   parameter int WIDTH = 32
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_load,
   input  wire logic             i_step,
   input  wire logic             i_fix,
   input  wire logic [5:0]       i_func,
   input  wire logic [WIDTH-1:0] i_a,
   input  wire logic [WIDTH-1:0] i_b,
   output logic      [WIDTH-1:0] o_res_hi,
   output logic      [WIDTH-1:0] o_res_lo
);
   import mips_pkg::*;

   localparam int W2 = 2 * WIDTH;

   logic             w_div;
   logic             w_signed;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

   // r_opd holds the multiplicand or the divisor; r_acc holds {upper, multiplier}
   // for multiply and {remainder, dividend/quotient} for divide.
   logic [WIDTH-1:0] r_opd;
   logic [W2-1:0]    r_acc;
   logic [WIDTH-1:0] r_a_raw;
   logic             r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div0;

   logic [WIDTH:0]   w_add_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic [W2-1:0]    w_acc_nx;
   logic [W2-1:0]    w_prod;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;

   assign w_div    = is_div_op(i_func);
   assign w_signed = is_signed_op(i_func);
   assign w_a_mag  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_b_mag  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

   assign w_add_sum = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, r_opd};
   assign w_rem_sh  = r_acc[W2-1:WIDTH-1];
   assign w_diff    = w_rem_sh - {1'b0, r_opd};

   always_comb begin
      w_acc_nx = r_acc;
      if (r_div) begin
         if (!w_diff[WIDTH]) begin
            w_acc_nx = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nx = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (r_acc[0]) begin
            w_acc_nx = {w_add_sum, r_acc[WIDTH-1:1]};
         end else begin
            w_acc_nx = {1'b0, r_acc[W2-1:1]};
         end
      end
   end

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opd    <= '0;
         r_acc    <= '0;
         r_a_raw  <= '0;
         r_div    <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         o_res_hi <= '0;
         o_res_lo <= '0;
      end else begin
         if (i_load) begin
            r_opd   <= w_div ? w_b_mag : w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
            r_a_raw <= i_a;
            r_div   <= w_div;
            r_neg_q <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= w_signed && i_a[WIDTH-1];
            r_div0  <= (i_b == '0);
         end else if (i_step) begin
            r_acc <= w_acc_nx;
         end
         if (i_fix) begin
            if (!r_div) begin
               o_res_hi <= w_prod[W2-1:WIDTH];
               o_res_lo <= w_prod[WIDTH-1:0];
            end else if (r_div0) begin
               o_res_hi <= r_a_raw;
               o_res_lo <= '1;
            end else begin
               o_res_hi <= w_rem;
               o_res_lo <= w_quo;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative MULT/MULTU/DIV/DIVU unit with private HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input wire logic       Clock_in,
   input wire logic       Reset_in,
   mul_div_unit_if.slave  md
);
   import mips_pkg::*;

   localparam int              CNT_W      = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH - 1);

   mdu_state_t       r_state;
   mdu_state_t       w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_wr_pend;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;
   logic             w_free;
   logic             w_accept;
   logic             w_step;
   logic             w_fix;
   logic             w_mthi;
   logic             w_mtlo;

   // The result is written one edge after FIX, so the unit also counts as
   // occupied while that write is pending (r_busy still high).
   assign w_free = (r_state == IDLE) && !r_busy;
   assign w_mthi = w_free && md.Start_in && (md.Func_in == c_FUNCT_MTHI);
   assign w_mtlo = w_free && md.Start_in && (md.Func_in == c_FUNCT_MTLO);

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      w_fix        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_free && md.Start_in && is_muldiv(md.Func_in)) begin
               w_accept     = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_cnt == '0) begin
               w_next_state = FIX;
            end
         end
         FIX: begin
            w_fix        = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clock_in) begin
      if (Reset_in) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_wr_pend <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_state   <= w_next_state;
         r_busy    <= (r_state != IDLE);
         r_wr_pend <= w_fix;
         r_done    <= r_wr_pend;
         if (w_accept) begin
            r_cnt <= c_CNT_LOAD;
         end else if (w_step) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (r_wr_pend) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else begin
            if (w_mthi) begin
               r_hi <= md.A_in;
            end
            if (w_mtlo) begin
               r_lo <= md.A_in;
            end
         end
      end
   end

   mdu_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk      (Clock_in),
      .rst      (Reset_in),
      .i_load   (w_accept),
      .i_step   (w_step),
      .i_fix    (w_fix),
      .i_func   (md.Func_in),
      .i_a      (md.A_in),
      .i_b      (md.B_in),
      .o_res_hi (w_res_hi),
      .o_res_lo (w_res_lo)
   );

   always_comb begin
      md.O_out = '0;
      if (md.Func_in == c_FUNCT_MFHI) begin
         md.O_out = r_hi;
      end else if (md.Func_in == c_FUNCT_MFLO) begin
         md.O_out = r_lo;
      end
   end

   assign md.Busy_out  = r_busy;
   assign md.Done_out  = r_done;
   assign md.Stall_out = r_busy && is_hilo_move(md.Func_in);

endmodule

`default_nettype wire
